// File: rtl/arb_sweep_scheduler.sv
// Sweeps the Bellman/CycleDetect engine over every source vertex and arbitrates adjmat writes between runs.
// Optional run watchdog is compiled in with `define SCHED_WATCHDOG_EN.
module arb_sweep_scheduler #(
  parameter int NUM_SRC = 8,
  parameter int SRC_W   = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             upd_req,
  output logic             upd_grant,
  output logic             eng_reset,
  output logic [SRC_W-1:0] eng_src,
  input  logic             eng_done,
  input  logic             eng_cycle,
  output logic             busy,
  output logic             cycle_valid,
  output logic [SRC_W-1:0] cycle_src,
  output logic             sweep_done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, HOLD, DONE} state_t;

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_SRC - 1);

  state_t           state, state_next;
  logic [SRC_W-1:0] idx, idx_next;
  logic             timed_out;

  logic             upd_grant_d, eng_reset_d, busy_d, cycle_valid_d, sweep_done_d, timeout_err_d;
  logic [SRC_W-1:0] eng_src_d, cycle_src_d;

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside WAIT, so every run starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign timed_out = (state == WAIT) && !eng_done && (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign timed_out = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      eng_reset   <= 1'b1;
      eng_src     <= '0;
      busy        <= 1'b0;
      upd_grant   <= 1'b0;
      cycle_valid <= 1'b0;
      cycle_src   <= '0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      eng_reset   <= eng_reset_d;
      eng_src     <= eng_src_d;
      busy        <= busy_d;
      upd_grant   <= upd_grant_d;
      cycle_valid <= cycle_valid_d;
      cycle_src   <= cycle_src_d;
      sweep_done  <= sweep_done_d;
      timeout_err <= timeout_err_d;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          idx_next   = '0;
          state_next = upd_req ? HOLD : LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT;
      WAIT: begin
        if (eng_done || timed_out)
          state_next = NEXT;
      end
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + SRC_W'(1);
          state_next = upd_req ? HOLD : LAUNCH;
        end
      end
      HOLD: begin
        if (!upd_req)
          state_next = LAUNCH;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything once a sweep has begun.
    if (stop && state != IDLE)
      state_next = IDLE;
  end

  // Outputs are computed from the upcoming state so that their registered copies line up with it.
  always_comb begin
    eng_reset_d   = (state_next != WAIT);
    eng_src_d     = (state_next == LAUNCH) ? idx_next : eng_src;
    busy_d        = (state_next != IDLE);
    upd_grant_d   = upd_req && (state_next == IDLE || state_next == HOLD);
    cycle_valid_d = (state == WAIT) && eng_done && eng_cycle && !stop;
    cycle_src_d   = cycle_valid_d ? idx : cycle_src;
    sweep_done_d  = (state_next == DONE);
    timeout_err_d = timeout_err || timed_out;
  end

endmodule

// File: tb/tb_arb_sweep_scheduler.sv
// Directed bench for arb_sweep_scheduler with a 4-source sweep and a fixed-latency engine model.
// Watchdog scenario is included when SCHED_WATCHDOG_EN is defined.
module tb_arb_sweep_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       upd_req = 1'b0;
  logic       upd_grant;
  logic       eng_reset;
  logic [1:0] eng_src;
  logic       eng_done;
  logic       eng_cycle;
  logic       busy;
  logic       cycle_valid;
  logic [1:0] cycle_src;
  logic       sweep_done;
  logic       timeout_err;

  int         checks = 0;
  int         failures = 0;

  int         eng_cnt = 0;
  logic [1:0] cyc_sel = 2'd2;
  logic       hang_en = 1'b0;

  always #5 clk = ~clk;

  arb_sweep_scheduler #(.NUM_SRC(4), .SRC_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .upd_req(upd_req), .upd_grant(upd_grant),
    .eng_reset(eng_reset), .eng_src(eng_src),
    .eng_done(eng_done), .eng_cycle(eng_cycle),
    .busy(busy), .cycle_valid(cycle_valid), .cycle_src(cycle_src),
    .sweep_done(sweep_done), .timeout_err(timeout_err)
  );

  // Engine model: done 10 cycles after reset release, cycle only for the selected source.
  always @(posedge clk) begin
    if (eng_reset) eng_cnt <= 0;
    else if (eng_cnt < 1000) eng_cnt <= eng_cnt + 1;
  end
  assign eng_done  = !eng_reset && (eng_cnt >= 10) && !(hang_en && eng_src == 2'd0);
  assign eng_cycle = eng_done && (eng_src == cyc_sel);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (eng_reset !== 1'b1) begin failures++; $display("[TB] FAIL reset_eng_reset got=%0b exp=1", eng_reset); end
    checks++; if (eng_src !== 2'd0) begin failures++; $display("[TB] FAIL reset_eng_src got=%0d exp=0", eng_src); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (upd_grant !== 1'b0) begin failures++; $display("[TB] FAIL reset_upd_grant got=%0b exp=0", upd_grant); end
    checks++; if (cycle_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cycle_valid got=%0b exp=0", cycle_valid); end
    checks++; if (sweep_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_sweep_done got=%0b exp=0", sweep_done); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err got=%0b exp=0", timeout_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    int busy_cnt = 0, cv_cnt = 0, sd_cnt = 0, sd_cyc = -1, runs = 0, first_low = -1, grant_cnt = 0;
    logic [1:0] cv_src = 2'd0;
    logic       prev_rst = 1'b1;
    logic [1:0] srcs [4];
    cyc_sel = 2'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (busy) busy_cnt++;
      if (cycle_valid) begin cv_cnt++; cv_src = cycle_src; end
      if (sweep_done) begin sd_cnt++; sd_cyc = c; end
      if (upd_grant) grant_cnt++;
      if (!eng_reset && prev_rst) begin
        if (runs < 4) srcs[runs] = eng_src;
        if (runs == 0) first_low = c;
        runs++;
      end
      prev_rst = eng_reset;
      step();
    end
    checks++; if (busy_cnt !== 53) begin failures++; $display("[TB] FAIL sweep_busy_cycles got=%0d exp=53", busy_cnt); end
    checks++; if (cv_cnt !== 1) begin failures++; $display("[TB] FAIL sweep_cycle_valid_count got=%0d exp=1", cv_cnt); end
    checks++; if (cv_src !== 2'd2) begin failures++; $display("[TB] FAIL sweep_cycle_src got=%0d exp=2", cv_src); end
    checks++; if (sd_cnt !== 1) begin failures++; $display("[TB] FAIL sweep_done_count got=%0d exp=1", sd_cnt); end
    checks++; if (sd_cyc !== 53) begin failures++; $display("[TB] FAIL sweep_done_cycle got=%0d exp=53", sd_cyc); end
    checks++; if (runs !== 4) begin failures++; $display("[TB] FAIL sweep_run_count got=%0d exp=4", runs); end
    checks++; if (first_low !== 2) begin failures++; $display("[TB] FAIL sweep_first_release got=%0d exp=2", first_low); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (srcs[i] !== 2'(i)) begin failures++; $display("[TB] FAIL sweep_src_order[%0d] got=%0d exp=%0d", i, srcs[i], i); end
    end
    checks++; if (grant_cnt !== 0) begin failures++; $display("[TB] FAIL sweep_spurious_grant got=%0d exp=0", grant_cnt); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL sweep_timeout_err got=%0b exp=0", timeout_err); end
  endtask

  task automatic test_update();
    int grant_cnt = 0, first = -1, last = -1, overlap = 0, low_after = -1, sd_cyc = -1;
    logic [1:0] src_at_33 = 2'd0;
    logic       prev_rst = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      upd_req = (c >= 20 && c <= 31);
      if (upd_grant) begin grant_cnt++; if (first < 0) first = c; last = c; end
      if (upd_grant && !eng_reset) overlap++;
      if (c == 33) src_at_33 = eng_src;
      if (!eng_reset && prev_rst && c > 30 && low_after < 0) low_after = c;
      if (sweep_done) sd_cyc = c;
      prev_rst = eng_reset;
      step();
    end
    upd_req = 1'b0;
    checks++; if (first !== 27) begin failures++; $display("[TB] FAIL upd_grant_rise got=%0d exp=27", first); end
    checks++; if (last !== 32) begin failures++; $display("[TB] FAIL upd_grant_fall got=%0d exp=32", last); end
    checks++; if (grant_cnt !== 6) begin failures++; $display("[TB] FAIL upd_grant_cycles got=%0d exp=6", grant_cnt); end
    checks++; if (overlap !== 0) begin failures++; $display("[TB] FAIL upd_grant_during_run got=%0d exp=0", overlap); end
    checks++; if (src_at_33 !== 2'd2) begin failures++; $display("[TB] FAIL upd_launch_src got=%0d exp=2", src_at_33); end
    checks++; if (low_after !== 34) begin failures++; $display("[TB] FAIL upd_src2_release got=%0d exp=34", low_after); end
    checks++; if (sd_cyc !== 59) begin failures++; $display("[TB] FAIL upd_sweep_done_cycle got=%0d exp=59", sd_cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL upd_busy_end got=%0b exp=0", busy); end
  endtask

  task automatic test_stop();
    int cv_cnt = 0, sd_cnt = 0, busy_after = 0;
    cyc_sel = 2'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      stop = (c == 51);
      if (cycle_valid) cv_cnt++;
      if (sweep_done) sd_cnt++;
      if (c > 52 && busy) busy_after++;
      if (c == 52) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_busy got=%0b exp=0", busy); end
        checks++; if (eng_reset !== 1'b1) begin failures++; $display("[TB] FAIL stop_eng_reset got=%0b exp=1", eng_reset); end
      end
      step();
    end
    stop = 1'b0;
    checks++; if (cv_cnt !== 0) begin failures++; $display("[TB] FAIL stop_cycle_valid_suppressed got=%0d exp=0", cv_cnt); end
    checks++; if (sd_cnt !== 0) begin failures++; $display("[TB] FAIL stop_no_sweep_done got=%0d exp=0", sd_cnt); end
    checks++; if (busy_after !== 0) begin failures++; $display("[TB] FAIL stop_stays_idle got=%0d exp=0", busy_after); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (eng_src !== 2'd0) begin failures++; $display("[TB] FAIL restart_src got=%0d exp=0", eng_src); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL restart_busy got=%0b exp=1", busy); end
    step();
    checks++; if (eng_reset !== 1'b0) begin failures++; $display("[TB] FAIL restart_release got=%0b exp=0", eng_reset); end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL restart_stop_busy got=%0b exp=0", busy); end
    cyc_sel = 2'd2;
    step();
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL startstop_busy got=%0b exp=0", busy); end
    checks++; if (eng_reset !== 1'b1) begin failures++; $display("[TB] FAIL startstop_eng_reset got=%0b exp=1", eng_reset); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL startstop_busy_later got=%0b exp=0", busy); end
    start = 1'b1; step();
    for (int c = 1; c <= 30; c++) begin
      start = (c == 20);
      if (c == 27) begin
        checks++; if (eng_src !== 2'd2) begin failures++; $display("[TB] FAIL busy_start_src got=%0d exp=2", eng_src); end
        checks++; if (eng_reset !== 1'b1) begin failures++; $display("[TB] FAIL busy_start_launch got=%0b exp=1", eng_reset); end
      end
      if (c == 28) begin
        checks++; if (eng_reset !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_release got=%0b exp=0", eng_reset); end
      end
      step();
    end
    start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    step();
  endtask

`ifdef SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int sd_cyc = -1, cv_cnt = 0;
    logic to_17 = 1'bx, to_18 = 1'bx;
    hang_en = 1'b1;
    cyc_sel = 2'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 17) to_17 = timeout_err;
      if (c == 18) to_18 = timeout_err;
      if (sweep_done) sd_cyc = c;
      if (cycle_valid) cv_cnt++;
      step();
    end
    hang_en = 1'b0;
    checks++; if (to_17 !== 1'b0) begin failures++; $display("[TB] FAIL wd_before_limit got=%0b exp=0", to_17); end
    checks++; if (to_18 !== 1'b1) begin failures++; $display("[TB] FAIL wd_at_limit got=%0b exp=1", to_18); end
    checks++; if (sd_cyc !== 58) begin failures++; $display("[TB] FAIL wd_sweep_done_cycle got=%0d exp=58", sd_cyc); end
    checks++; if (cv_cnt !== 1) begin failures++; $display("[TB] FAIL wd_cycle_valid_count got=%0d exp=1", cv_cnt); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL wd_sticky got=%0b exp=1", timeout_err); end
  endtask
`endif

  task automatic test_reset_mid();
    cyc_sel = 2'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 20; c++) step();
    upd_req = 1'b1;
    reset = 1'b1;
    step();
    checks++; if (eng_reset !== 1'b1) begin failures++; $display("[TB] FAIL midreset_eng_reset got=%0b exp=1", eng_reset); end
    checks++; if (eng_src !== 2'd0) begin failures++; $display("[TB] FAIL midreset_eng_src got=%0d exp=0", eng_src); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%0b exp=0", busy); end
    checks++; if (upd_grant !== 1'b0) begin failures++; $display("[TB] FAIL midreset_upd_grant got=%0b exp=0", upd_grant); end
    checks++; if (cycle_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_cycle_valid got=%0b exp=0", cycle_valid); end
    checks++; if (cycle_src !== 2'd0) begin failures++; $display("[TB] FAIL midreset_cycle_src got=%0d exp=0", cycle_src); end
    checks++; if (sweep_done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_sweep_done got=%0b exp=0", sweep_done); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_timeout_err got=%0b exp=0", timeout_err); end
    reset = 1'b0;
    upd_req = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_update();
    test_stop();
    test_start_stop();
`ifdef SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
